// File: rtl/counter_nbit.sv
// N-bit modulo up/down counter with clear, clamped load, wrap/saturate
// limit handling, a registered wrap pulse and a sticky overflow flag.
module counter_nbit #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             ovf
);

  if (WIDTH < 1 || MODULUS < 2 || (WIDTH < 31 && MODULUS > (1 << WIDTH))) begin : g_bad_cfg
    $error("counter_nbit: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             limit;

  assign at_max = (count_q == MAX_V);
  assign at_min = (count_q == '0);
  assign limit  = up_dn ? at_max : at_min;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en) begin
      if (limit) begin
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
        // Saturate holds at the limit; wrap jumps to the opposite end.
        if (SATURATE == 0) begin
          count_d = up_dn ? '0 : MAX_V;
        end
      end else begin
        count_d = up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_counter_nbit.sv
// Bench for counter_nbit: three configurations driven in parallel, checked
// every cycle against an arithmetic model plus directed literal expectations.
module tb_counter_nbit;

  logic clk, rst, clr, load, en, up_dn;
  logic [3:0] load_val;
  logic [2:0][3:0] cnt;
  logic [2:0] amx, amn, wr, ov;

  int n_cmp = 0;
  int n_bad = 0;

  int MODS[3] = '{10, 10, 16};
  int SATS[3] = '{0, 1, 0};
  int mc[3], mw[3], mo[3];

  counter_nbit #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap10 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .count(cnt[0]), .at_max(amx[0]), .at_min(amn[0]), .wrap(wr[0]), .ovf(ov[0]));
  counter_nbit #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat10 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .count(cnt[1]), .at_max(amx[1]), .at_min(amn[1]), .wrap(wr[1]), .ovf(ov[1]));
  counter_nbit #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_wrap16 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .count(cnt[2]), .at_max(amx[2]), .at_min(amn[2]), .wrap(wr[2]), .ovf(ov[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: counting is modular arithmetic on the range 0..M-1.
  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        mc[i] = 0; mw[i] = 0; mo[i] = 0;
      end else if (clr) begin
        mc[i] = 0; mw[i] = 0; mo[i] = 0;
      end else if (load) begin
        mc[i] = (int'(load_val) < MODS[i]) ? int'(load_val) : MODS[i] - 1;
        mw[i] = 0;
      end else if (en) begin
        int nxt;
        nxt = mc[i] + (up_dn ? 1 : -1);
        if (nxt < 0 || nxt >= MODS[i]) begin
          mw[i] = 1; mo[i] = 1;
          if (SATS[i] == 0) mc[i] = (nxt + MODS[i]) % MODS[i];
        end else begin
          mw[i] = 0;
          mc[i] = nxt;
        end
      end else begin
        mw[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model%0d.count", i), int'(cnt[i]), mc[i]);
      chk($sformatf("model%0d.at_max", i), int'(amx[i]), int'(mc[i] == MODS[i] - 1));
      chk($sformatf("model%0d.at_min", i), int'(amn[i]), int'(mc[i] == 0));
      chk($sformatf("model%0d.wrap", i), int'(wr[i]), mw[i]);
      chk($sformatf("model%0d.ovf", i), int'(ov[i]), mo[i]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int exp1[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp2[4]  = '{1, 0, 9, 8};
  int exp3w[4] = '{0, 1, 1, 1};
  int exp6[4]  = '{15, 0, 1, 0};

  initial begin
    rst = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 3; i++) begin
      chk("reset.count", int'(cnt[i]), 0);
      chk("reset.at_min", int'(amn[i]), 1);
      chk("reset.at_max", int'(amx[i]), 0);
      chk("reset.ovf", int'(ov[i]), 0);
    end
    rst = 1'b1;

    // Wrap-mode count up through the modulus.
    en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("t1.count", int'(cnt[0]), exp1[k]);
      chk("t1.wrap", int'(wr[0]), int'(k == 9));
      chk("t1.ovf", int'(ov[0]), int'(k >= 9));
      chk("t1.at_max", int'(amx[0]), int'(k == 8));
    end

    // Load then count down across zero.
    en = 1'b0; load = 1'b1; load_val = 4'd2;
    step();
    chk("t2.load", int'(cnt[0]), 2);
    chk("t2.ovf_kept", int'(ov[0]), 1);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2.count", int'(cnt[0]), exp2[k]);
      chk("t2.wrap", int'(wr[0]), int'(k == 2));
      chk("t2.at_min", int'(amn[0]), int'(k == 1));
    end

    // Saturating instance held at the top.
    en = 1'b0; load = 1'b1; load_val = 4'd8; up_dn = 1'b1;
    step();
    chk("t3.load", int'(cnt[1]), 8);
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3.count", int'(cnt[1]), 9);
      chk("t3.wrap", int'(wr[1]), exp3w[k]);
    end
    chk("t3.ovf", int'(ov[1]), 1);
    en = 1'b0; clr = 1'b1;
    step();
    chk("t3.clr_count", int'(cnt[1]), 0);
    chk("t3.clr_ovf", int'(ov[1]), 0);
    chk("t3.clr_wrap", int'(wr[1]), 0);

    // Priority and load clamp.
    clr = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1;
    step();
    chk("t4.prio", int'(cnt[0]), 0);
    clr = 1'b0; en = 1'b0; load_val = 4'd15;
    step();
    chk("t4.clamp10", int'(cnt[0]), 9);
    chk("t4.noclamp16", int'(cnt[2]), 15);
    chk("t4.ovf", int'(ov[0]), 0);

    // Asynchronous reset between edges.
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step();
    en = 1'b0; load = 1'b1; load_val = 4'd6;
    step();
    load = 1'b0; en = 1'b1;
    step();
    chk("t5.pre_count", int'(cnt[0]), 7);
    chk("t5.pre_ovf", int'(ov[0]), 1);
    #2 rst = 1'b0;
    #1;
    chk("t5.async_count", int'(cnt[0]), 0);
    chk("t5.async_ovf", int'(ov[0]), 0);
    chk("t5.async_wrap", int'(wr[0]), 0);
    step();
    chk("t5.held", int'(cnt[0]), 0);
    #1 rst = 1'b1;
    #2;
    chk("t5.released", int'(cnt[0]), 0);
    step();
    chk("t5.first_edge", int'(cnt[0]), 1);

    // Full binary range wraps by natural overflow; direction flip is immediate.
    en = 1'b0; load = 1'b1; load_val = 4'd14;
    step();
    chk("t6.load", int'(cnt[2]), 14);
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) up_dn = 1'b0;
      step();
      chk("t6.count", int'(cnt[2]), exp6[k]);
      chk("t6.wrap", int'(wr[2]), int'(k == 1));
    end
    en = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
